screen_rx: RTL and testbench

- Decodes the serial LED-matrix drive signals (row/column shift registers plus latch) back into a 16x16 framebuffer.
- Used as the receive end of the `screen` link. Typical uses:
  - a loopback monitor in simulation and on hardware, so game state can be checked without looking at LEDs;
  - a mirror display on a second board.
- Samples the serial lines with the system clock, reconstructs each latched row, and exposes the image through a registered read port with frame-completion and error reporting.

---
 rtl/screen_rx.sv | 124 ++++++++++++
 tb/tb_screen_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/screen_rx.sv
// screen_rx: rebuilds a 16x16 framebuffer from the serial row/column/latch LED-drive lines.
// Define SCREEN_RX_SYNC_EN to add 2-flop synchronizers when the transmitter runs on a foreign clock.
module screen_rx #(
  parameter int ROWS = 16,
  parameter int COLS = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rclk,
  input  logic            rsdi,
  input  logic            cclk,
  input  logic            csdi,
  input  logic            le,
  input  logic            oeb,
  input  logic [3:0]      rd_row,
  output logic [COLS-1:0] rd_data,
  output logic            blank,
  output logic            frame_done,
  output logic [7:0]      row_err_cnt
);

  localparam int IdxW = $clog2(ROWS);
  localparam int CntW = $clog2(ROWS + 1);

  logic            w_rclk, w_rsdi, w_cclk, w_csdi, w_le, w_oeb;
  logic [2:0]      r_hist;
  logic            w_rclkRise, w_cclkRise, w_leRise;
  logic [ROWS-1:0] r_rowsr;
  logic [COLS-1:0] r_colsr;
  logic [COLS-1:0] r_fb [ROWS];
  logic [COLS-1:0] r_rdData;
  logic            r_blank;
  logic            r_frameDone;
  logic [7:0]      r_errCnt;
  logic [CntW-1:0] w_ones;
  logic [IdxW-1:0] w_idx;
  logic            w_oneHot;

`ifdef SCREEN_RX_SYNC_EN
  logic [5:0] r_sync1, r_sync2;

  // Every line goes through the same two stages so data stays aligned with its shift clock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
    end else begin
      r_sync1 <= {oeb, le, csdi, cclk, rsdi, rclk};
      r_sync2 <= r_sync1;
      r_hist  <= {r_sync2[4], r_sync2[2], r_sync2[0]};
    end
  end

  assign {w_oeb, w_le, w_csdi, w_cclk, w_rsdi, w_rclk} = r_sync2;
`else
  // Same-clock transmitter: the pins are the current sample and one flop holds the history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hist <= '0;
    end else begin
      r_hist <= {le, cclk, rclk};
    end
  end

  assign {w_oeb, w_le, w_csdi, w_cclk, w_rsdi, w_rclk} = {oeb, le, csdi, cclk, rsdi, rclk};
`endif

  assign w_rclkRise = w_rclk & ~r_hist[0];
  assign w_cclkRise = w_cclk & ~r_hist[1];
  assign w_leRise   = w_le   & ~r_hist[2];

  always_comb begin
    w_ones = '0;
    w_idx  = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (r_rowsr[i]) begin
        w_ones = w_ones + CntW'(1);
        w_idx  = IdxW'(i);
      end
    end
  end

  assign w_oneHot = (w_ones == CntW'(1));

  // Commit reads the pre-shift register values, so a coincident shift edge lands only in the next commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rowsr     <= '0;
      r_colsr     <= '0;
      r_rdData    <= '0;
      r_blank     <= 1'b1;
      r_frameDone <= 1'b0;
      r_errCnt    <= '0;
      for (int r = 0; r < ROWS; r++) begin
        r_fb[r] <= '0;
      end
    end else begin
      r_frameDone <= 1'b0;
      r_blank     <= w_oeb;
      r_rdData    <= r_fb[rd_row];
      if (w_rclkRise) begin
        r_rowsr <= {r_rowsr[ROWS-2:0], w_rsdi};
      end
      if (w_cclkRise) begin
        r_colsr <= {r_colsr[COLS-2:0], w_csdi};
      end
      if (w_leRise) begin
        if (w_oneHot) begin
          r_fb[w_idx] <= r_colsr;
          r_frameDone <= (w_idx == IdxW'(ROWS - 1));
        end else if (r_errCnt != 8'hFF) begin
          r_errCnt <= r_errCnt + 8'd1;
        end
      end
    end
  end

  assign rd_data     = r_rdData;
  assign blank       = r_blank;
  assign frame_done  = r_frameDone;
  assign row_err_cnt = r_errCnt;

endmodule

// File: tb/tb_screen_rx.sv
// tb_screen_rx: drives screen_rx like the serial LED transmitter and compares against a framebuffer model.
module tb_screen_rx;

  localparam int HOLD = 3;

  logic        clk = 1'b0;
  logic        reset, rclk, rsdi, cclk, csdi, le, oeb;
  logic [3:0]  rd_row;
  logic [15:0] rd_data;
  logic        blank, frame_done;
  logic [7:0]  row_err_cnt;

  int checks   = 0;
  int failures = 0;
  int fdCount  = 0;
  int expFd    = 0;
  int expErr   = 0;
  logic [15:0] expFb [16];
  logic [15:0] rowModel, colModel;
  logic [15:0] data, wordW, wordR;
  logic [7:0]  partial;
  logic        extraBit;

  screen_rx dut (
    .clk(clk), .reset(reset), .rclk(rclk), .rsdi(rsdi), .cclk(cclk), .csdi(csdi),
    .le(le), .oeb(oeb), .rd_row(rd_row), .rd_data(rd_data), .blank(blank),
    .frame_done(frame_done), .row_err_cnt(row_err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fdCount++;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // A latch writes the column word into the row named by a one-hot row word; anything else is an error.
  task automatic modelCommit(input logic [15:0] r, input logic [15:0] c);
    int n = 0;
    int idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (r[i]) begin
        n++;
        idx = i;
      end
    end
    if (n == 1) begin
      expFb[idx] = c;
      if (idx == 15) expFd++;
    end else if (expErr < 255) begin
      expErr++;
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    rclk = 1'b0; cclk = 1'b0; le = 1'b0; rsdi = 1'b0; csdi = 1'b0;
    waitCycles(3);
    reset = 1'b1;
    for (int r = 0; r < 16; r++) expFb[r] = 16'h0000;
    rowModel = 16'h0000;
    colModel = 16'h0000;
    expErr   = 0;
  endtask

  task automatic shiftPair(input bit doRow, input bit rBit, input bit doCol, input bit cBit);
    rsdi = rBit;
    csdi = cBit;
    waitCycles(HOLD);
    rclk = doRow;
    cclk = doCol;
    if (doRow) rowModel = {rowModel[14:0], rBit};
    if (doCol) colModel = {colModel[14:0], cBit};
    waitCycles(HOLD);
    rclk = 1'b0;
    cclk = 1'b0;
  endtask

  task automatic latch();
    waitCycles(HOLD);
    le = 1'b1;
    modelCommit(rowModel, colModel);
    waitCycles(HOLD);
    le = 1'b0;
    waitCycles(HOLD);
  endtask

  task automatic applyStimulus(input logic [15:0] rowW, input logic [15:0] colW, input bit doLatch);
    for (int i = 15; i >= 0; i--) shiftPair(1'b1, rowW[i], 1'b1, colW[i]);
    if (doLatch) latch();
  endtask

  task automatic readRow(input int r, output logic [15:0] d);
    rd_row = 4'(r);
    waitCycles(2);
    d = rd_data;
  endtask

  task automatic checkFb(input string tag);
    logic [15:0] d;
    for (int r = 0; r < 16; r++) begin
      readRow(r, d);
      checkOutput($sformatf("%s_row%0d", tag, r), {16'h0, d}, {16'h0, expFb[r]});
    end
  endtask

  initial begin
    oeb = 1'b1;
    rd_row = 4'd0;
    doReset();
    waitCycles(1);
    checkOutput("reset_blank", {31'h0, blank}, 32'd1);
    checkOutput("reset_err", {24'h0, row_err_cnt}, 32'd0);
    checkOutput("reset_frame_done", {31'h0, frame_done}, 32'd0);
    checkFb("reset");

    applyStimulus(16'h0001, 16'hA5A5, 1'b1);
    readRow(0, data);
    checkOutput("row0_word", {16'h0, data}, 32'h0000A5A5);
    checkOutput("row0_no_frame_done", fdCount, 0);

    for (int r = 0; r < 15; r++) applyStimulus(16'(1 << r), 16'(r * 16'h0101), 1'b1);
    checkOutput("fd_before_row15", fdCount, 0);
    applyStimulus(16'h8000, 16'hFFFF & (16'd15 * 16'h0101), 1'b1);
    checkOutput("fd_after_row15", fdCount, 1);
    checkFb("frame");

    applyStimulus(16'h0000, 16'($urandom), 1'b1);
    applyStimulus(16'h0300, 16'($urandom), 1'b1);
    checkOutput("err_two", {24'h0, row_err_cnt}, 32'd2);
    checkFb("bad_rows");
    repeat (300) latch();
    checkOutput("err_saturated", {24'h0, row_err_cnt}, 32'd255);
    checkOutput("err_model", {24'h0, row_err_cnt}, expErr);

    // le and cclk rise together: the commit must take the column word from before that shift.
    wordW = 16'($urandom);
    extraBit = 1'($urandom);
    applyStimulus(16'h0002, wordW, 1'b0);
    csdi = extraBit;
    waitCycles(HOLD);
    modelCommit(rowModel, colModel);
    colModel = {colModel[14:0], extraBit};
    cclk = 1'b1;
    le = 1'b1;
    waitCycles(HOLD);
    cclk = 1'b0;
    le = 1'b0;
    waitCycles(HOLD);
    readRow(1, data);
    checkOutput("coincident_commit", {16'h0, data}, {16'h0, wordW});
    latch();
    readRow(1, data);
    checkOutput("coincident_next", {16'h0, data}, {16'h0, wordW[14:0], extraBit});

    for (int i = 0; i < 8; i++) shiftPair(1'b1, 1'($urandom), 1'b1, 1'($urandom));
    doReset();
    partial = 8'($urandom);
    for (int i = 15; i >= 0; i--) shiftPair(1'b1, i == 3, i < 8, (i < 8) ? partial[i & 7] : 1'b0);
    latch();
    readRow(3, data);
    checkOutput("reset_partial_word", {16'h0, data}, {24'h0, partial});
    checkOutput("reset_err_cleared", {24'h0, row_err_cnt}, 32'd0);
    checkFb("post_reset");

    for (int k = 0; k < 12; k++) begin
      wordR = ($urandom_range(0, 2) != 0) ? 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
      applyStimulus(wordR, 16'($urandom), 1'b1);
    end
    checkFb("random");
    checkOutput("random_err", {24'h0, row_err_cnt}, expErr);
    checkOutput("random_frame_done", fdCount, expFd);

    oeb = 1'b0;
    waitCycles(5);
    checkOutput("blank_low", {31'h0, blank}, 32'd0);
    oeb = 1'b1;
    waitCycles(5);
    checkOutput("blank_high", {31'h0, blank}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
